// File: rtl/facto_core.sv
// ---------------------------------------------------------------------------
// facto_core
//
// Register and compute stage of the factorial slave. It decodes bus writes,
// holds the control and operand registers, and computes operand! modulo
// 2^128. Each factor is applied with a 64-cycle shift-add multiplier. The
// status and result registers feed the slave's read-data output-select
// stage, and an interrupt is raised on completion.
//
// Ports:
//   clk        - single clock, all state updates on the rising edge
//   reset_n    - asynchronous active-low reset
//   s_sel      - slave select
//   s_wr       - write strobe (a write is s_sel & s_wr)
//   s_addr     - byte offset, decoded on s_addr[7:3]
//   s_din      - 64-bit write data
//   opdone     - status word: bit 1 = done, bit 0 = busy
//   result_h   - result[127:64]
//   result_l   - result[63:0]
//   interrupt  - intr_en & done
// ---------------------------------------------------------------------------
module facto_core (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_sel,
    input  logic        s_wr,
    input  logic [7:0]  s_addr,
    input  logic [63:0] s_din,
    output logic [63:0] opdone,
    output logic [63:0] result_h,
    output logic [63:0] result_l,
    output logic        interrupt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [63:0]    operand;
    logic           intr_en;
    logic [127:0]   result;
    logic [63:0]    multiplier;
    logic [127:0]   acc;
    logic [127:0]   mcand;
    logic [5:0]     step_cnt;
    logic [63:0]    count;
    logic           done;
    logic           busy;

    logic           wr;
    logic [4:0]     reg_sel;
    logic           wr_start;
    logic           wr_clear;
    logic           wr_intr;
    logic           wr_operand;
    logic [127:0]   acc_sum;
    logic [63:0]    count_dec;
    logic           unused_addr_bits;

    // Byte-lane bits of the address carry no meaning for this register map.
    assign unused_addr_bits = ^s_addr[2:0];

    // Write decode. opstart and opclear only act when data bit 0 is set.
    assign wr         = s_sel & s_wr;
    assign reg_sel    = s_addr[7:3];
    assign wr_start   = wr && (reg_sel == 5'h00) && s_din[0];
    assign wr_clear   = wr && (reg_sel == 5'h01) && s_din[0];
    assign wr_intr    = wr && (reg_sel == 5'h03);
    assign wr_operand = wr && (reg_sel == 5'h04);

    // One shift-add iteration: add the shifted multiplicand when the current
    // multiplier LSB is set. The sum is also what lands in result at step end,
    // so the final cycle's add is included.
    assign acc_sum   = multiplier[0] ? (acc + mcand) : acc;
    assign count_dec = count - 64'd1;

    // Main control FSM and datapath. opclear has priority over everything
    // except intr_en, so an opclear in the last MUL cycle suppresses DONE.
    // Each step multiplies the running product by the current factor; the
    // multiplier register is a shifting copy of count reloaded every step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            operand    <= 64'd0;
            intr_en    <= 1'b0;
            result     <= 128'd0;
            multiplier <= 64'd0;
            acc        <= 128'd0;
            mcand      <= 128'd0;
            step_cnt   <= 6'd0;
            count      <= 64'd0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (wr_intr) begin
                intr_en <= s_din[0];
            end

            if (wr_clear) begin
                state    <= IDLE;
                done     <= 1'b0;
                busy     <= 1'b0;
                result   <= 128'd0;
                acc      <= 128'd0;
                mcand    <= 128'd0;
                count    <= 64'd0;
                step_cnt <= 6'd0;
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                        if (wr_operand) begin
                            operand <= s_din;
                        end
                        if (wr_start) begin
                            done   <= 1'b0;
                            result <= 128'd1;
                            if (operand <= 64'd1) begin
                                state <= DONE;
                            end else begin
                                multiplier <= operand;
                                count      <= operand;
                                acc        <= 128'd0;
                                mcand      <= 128'd1;
                                step_cnt   <= 6'd0;
                                busy       <= 1'b1;
                                state      <= MUL;
                            end
                        end
                    end

                    MUL: begin
                        acc        <= acc_sum;
                        mcand      <= mcand << 1;
                        multiplier <= multiplier >> 1;
                        step_cnt   <= step_cnt + 6'd1;
                        if (step_cnt == 6'd63) begin
                            result <= acc_sum;
                            count  <= count_dec;
                            if (count_dec == 64'd1) begin
                                busy  <= 1'b0;
                                state <= DONE;
                            end else begin
                                acc        <= 128'd0;
                                mcand      <= acc_sum;
                                multiplier <= count_dec;
                                step_cnt   <= 6'd0;
                            end
                        end
                    end

                    DONE: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                        if (wr_operand) begin
                            operand <= s_din;
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign opdone    = {62'd0, done, busy};
    assign result_h  = result[127:64];
    assign result_l  = result[63:0];
    assign interrupt = intr_en & done;

endmodule
